// File: rtl/timer_sched_pkg.sv
// Shared types and default sizing for the multi-channel timer scheduler.
package timer_sched_pkg;

   localparam int DefChannels      = 4;
   localparam int DefWidth         = 16;
   localparam int DefPrescaleWidth = 8;

   typedef logic [$clog2(DefChannels)-1:0] chan_idx_t;

   typedef enum logic {
      PERIODIC = 1'b0,
      ONESHOT  = 1'b1
   } timer_mode_e;

   typedef struct packed {
      logic                arm;
      timer_mode_e         oneshot;
      logic [DefWidth-1:0] period;
   } timer_cfg_t;

endpackage

// File: rtl/timer_channel.sv
// One period timer: counts prescaler ticks, raises a pending event on expiry
// and records overrun when an earlier event has not yet been taken.
module timer_channel
   import timer_sched_pkg::*;
#(
   parameter int Width = DefWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             cfg_load,
   input  logic             cfg_arm,
   input  logic             cfg_oneshot,
   input  logic [Width-1:0] cfg_period,
   input  logic             consume,
   output logic             armed,
   output logic             pending,
   output logic             overrun
);

   logic [Width-1:0] count_r, count_s;
   logic [Width-1:0] period_r, period_s;
   logic             armed_r, armed_s;
   logic             pending_r, pending_s;
   logic             overrun_r, overrun_s;
   timer_mode_e      mode_r, mode_s;

   // Next-state: config beats the tick; a new expiry beats a same-cycle consume.
   always_comb begin
      count_s   = count_r;
      period_s  = period_r;
      armed_s   = armed_r;
      mode_s    = mode_r;
      overrun_s = overrun_r;
      if (consume) begin
         pending_s = 1'b0;
      end else begin
         pending_s = pending_r;
      end
      if (cfg_load && !cfg_arm) begin
         armed_s   = 1'b0;
         pending_s = 1'b0;
         overrun_s = 1'b0;
      end else if (cfg_load) begin
         count_s  = cfg_period;
         period_s = cfg_period;
         armed_s  = 1'b1;
         mode_s   = cfg_oneshot ? ONESHOT : PERIODIC;
      end else if (tick && armed_r) begin
         if (count_r == {Width{1'b0}}) begin
            pending_s = 1'b1;
            // Only an event that is not leaving this cycle is lost.
            if (pending_r && !consume) begin
               overrun_s = 1'b1;
            end else begin
               overrun_s = overrun_r;
            end
            if (mode_r == ONESHOT) begin
               armed_s = 1'b0;
            end else begin
               count_s = period_r;
            end
         end else begin
            count_s = count_r - {{(Width-1){1'b0}}, 1'b1};
         end
      end else begin
         count_s = count_r;
      end
   end

   // Channel state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r   <= {Width{1'b0}};
         period_r  <= {Width{1'b0}};
         armed_r   <= 1'b0;
         mode_r    <= PERIODIC;
         pending_r <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         count_r   <= count_s;
         period_r  <= period_s;
         armed_r   <= armed_s;
         mode_r    <= mode_s;
         pending_r <= pending_s;
         overrun_r <= overrun_s;
      end
   end

   assign armed   = armed_r;
   assign pending = pending_r;
   assign overrun = overrun_r;

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel timer scheduler: shared prescaler, per-channel timers and a
// round-robin arbitrated single-event output port.
module timer_scheduler
   import timer_sched_pkg::*;
#(
   parameter int Channels      = DefChannels,
   parameter int Width         = DefWidth,
   parameter int PrescaleWidth = DefPrescaleWidth
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [PrescaleWidth-1:0]    prescale,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [$clog2(Channels)-1:0] cfg_chan,
   input  logic                        cfg_arm,
   input  logic                        cfg_oneshot,
   input  logic [Width-1:0]            cfg_period,
   output logic                        tick,
   output logic                        expire_valid,
   input  logic                        expire_ready,
   output logic [$clog2(Channels)-1:0] expire_chan,
   output logic [Channels-1:0]         armed,
   output logic [Channels-1:0]         overrun
);

   localparam int ChanW = $clog2(Channels);

   logic [PrescaleWidth-1:0] presc_r;
   logic                     active_r;
   logic                     cfg_fire_s;
   logic [Channels-1:0]      cfg_load_s;
   logic [Channels-1:0]      pending_s;
   logic [Channels-1:0]      consume_s;
   logic                     load_s;
   logic                     grant_found_s;
   logic [ChanW-1:0]         grant_idx_s;
   logic [ChanW-1:0]         scan_idx_s;
   logic [ChanW-1:0]         ptr_r;
   logic                     valid_r;
   logic [ChanW-1:0]         chan_r;

   // Low only between reset and the first clock after release; gates tick and config.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_r <= 1'b0;
      end else begin
         active_r <= 1'b1;
      end
   end

   assign tick       = enable && active_r && (presc_r == {PrescaleWidth{1'b0}});
   assign cfg_ready  = active_r;
   assign cfg_fire_s = cfg_valid && active_r;

   // Prescaler down-counter; prescale is sampled only when reloading.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {PrescaleWidth{1'b0}};
      end else if (tick) begin
         presc_r <= prescale;
      end else if (enable && active_r) begin
         presc_r <= presc_r - {{(PrescaleWidth-1){1'b0}}, 1'b1};
      end else begin
         presc_r <= presc_r;
      end
   end

   for (genvar gi = 0; gi < Channels; gi++) begin : g_chan
      assign cfg_load_s[gi] = cfg_fire_s && (cfg_chan == ChanW'(gi));

      timer_channel #(
         .Width (Width)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick        (tick),
         .cfg_load    (cfg_load_s[gi]),
         .cfg_arm     (cfg_arm),
         .cfg_oneshot (cfg_oneshot),
         .cfg_period  (cfg_period),
         .consume     (consume_s[gi]),
         .armed       (armed[gi]),
         .pending     (pending_s[gi]),
         .overrun     (overrun[gi])
      );
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = ptr_r;
      scan_idx_s    = {ChanW{1'b0}};
      for (int i = 1; i <= Channels; i++) begin
         scan_idx_s = ChanW'((int'(ptr_r) + i) % Channels);
         if (!grant_found_s && pending_s[scan_idx_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = scan_idx_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign load_s    = !valid_r || expire_ready;
   assign consume_s = (load_s && grant_found_s) ?
                      ({{(Channels-1){1'b0}}, 1'b1} << grant_idx_s) :
                      {Channels{1'b0}};

   // Output register; holds its event while stalled, even across a disarm.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         chan_r  <= {ChanW{1'b0}};
         ptr_r   <= ChanW'(Channels - 1);
      end else if (load_s) begin
         valid_r <= grant_found_s;
         if (grant_found_s) begin
            chan_r <= grant_idx_s;
            ptr_r  <= grant_idx_s;
         end else begin
            chan_r <= chan_r;
            ptr_r  <= ptr_r;
         end
      end else begin
         valid_r <= valid_r;
         chan_r  <= chan_r;
         ptr_r   <= ptr_r;
      end
   end

   assign expire_valid = valid_r;
   assign expire_chan  = chan_r;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: tick-spacing vector table plus
// directed sequences whose expected events flow through a scoreboard queue.
module tb_timer_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [7:0]  prescale;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_chan;
   logic        cfg_arm;
   logic        cfg_oneshot;
   logic [15:0] cfg_period;
   logic        tick;
   logic        expire_valid;
   logic        expire_ready;
   logic [1:0]  expire_chan;
   logic [3:0]  armed;
   logic [3:0]  overrun;

   typedef struct {
      logic       en;
      logic [7:0] presc;
      logic       exp_tick;
   } tick_vec_t;

   typedef struct {
      logic [1:0] chan;
      int         cyc;
   } evt_t;

   tick_vec_t vecs [14];
   evt_t      sb_q [$];
   evt_t      mon_e;
   int        vec_cnt = 0;
   int        err_cnt = 0;
   int        cyc_cnt = 0;
   int        a;
   int        b;

   timer_scheduler #(
      .Channels      (4),
      .Width         (16),
      .PrescaleWidth (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .prescale     (prescale),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_chan     (cfg_chan),
      .cfg_arm      (cfg_arm),
      .cfg_oneshot  (cfg_oneshot),
      .cfg_period   (cfg_period),
      .tick         (tick),
      .expire_valid (expire_valid),
      .expire_ready (expire_ready),
      .expire_chan  (expire_chan),
      .armed        (armed),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Scoreboard: every accepted event must match the next expected one.
   always @(negedge clk) begin
      if (rst_n && expire_valid && expire_ready) begin
         if (sb_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_event: got chan %0d at cycle %0d, want no event", expire_chan, cyc_cnt);
         end else begin
            mon_e = sb_q.pop_front();
            check("event_chan", {30'd0, expire_chan}, {30'd0, mon_e.chan});
            check("event_cycle", cyc_cnt, mon_e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] ch, input logic arm, input logic one, input logic [15:0] per);
      cfg_valid   = 1'b1;
      cfg_chan    = ch;
      cfg_arm     = arm;
      cfg_oneshot = one;
      cfg_period  = per;
      step();
      cfg_valid   = 1'b0;
   endtask

   task automatic expect_evt(input logic [1:0] ch, input int cyc);
      evt_t e;
      e.chan = ch;
      e.cyc  = cyc;
      sb_q.push_back(e);
   endtask

   task automatic reset_dut();
      rst_n        = 1'b0;
      cfg_valid    = 1'b0;
      enable       = 1'b1;
      prescale     = 8'd0;
      expire_ready = 1'b1;
      #2;
      rst_n = 1'b1;
      sb_q.delete();
      step();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tick"}, {31'd0, tick}, 32'd0);
      check({tag, "_expire_valid"}, {31'd0, expire_valid}, 32'd0);
      check({tag, "_expire_chan"}, {30'd0, expire_chan}, 32'd0);
      check({tag, "_armed"}, {28'd0, armed}, 32'd0);
      check({tag, "_overrun"}, {28'd0, overrun}, 32'd0);
      check({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      enable       = 1'b0;
      prescale     = 8'd0;
      cfg_valid    = 1'b0;
      cfg_chan     = 2'd0;
      cfg_arm      = 1'b0;
      cfg_oneshot  = 1'b0;
      cfg_period   = 16'd0;
      expire_ready = 1'b0;

      // Tick spacing: prescale 3, a 2-cycle enable gap, prescale changes only taken at reload.
      vecs[0]  = '{1'b1, 8'd3, 1'b1};
      vecs[1]  = '{1'b1, 8'd3, 1'b0};
      vecs[2]  = '{1'b1, 8'd3, 1'b0};
      vecs[3]  = '{1'b1, 8'd3, 1'b0};
      vecs[4]  = '{1'b1, 8'd3, 1'b1};
      vecs[5]  = '{1'b1, 8'd0, 1'b0};
      vecs[6]  = '{1'b0, 8'd0, 1'b0};
      vecs[7]  = '{1'b0, 8'd0, 1'b0};
      vecs[8]  = '{1'b1, 8'd0, 1'b0};
      vecs[9]  = '{1'b1, 8'd0, 1'b0};
      vecs[10] = '{1'b1, 8'd1, 1'b1};
      vecs[11] = '{1'b1, 8'd1, 1'b0};
      vecs[12] = '{1'b1, 8'd1, 1'b1};
      vecs[13] = '{1'b0, 8'd1, 1'b0};

      #3;
      check_idle_outputs("reset");
      #9;
      rst_n = 1'b1;
      step();
      check("cfg_ready_after_release", {31'd0, cfg_ready}, 32'd1);

      for (int i = 0; i < 14; i++) begin
         enable   = vecs[i].en;
         prescale = vecs[i].presc;
         #1;
         check($sformatf("tick_vec%0d", i), {31'd0, tick}, {31'd0, vecs[i].exp_tick});
         step();
      end

      // Periodic ch1, period 2: events every 3 cycles, disarm lands on an expiring tick.
      reset_dut();
      a = cyc_cnt;
      expect_evt(2'd1, a + 5);
      expect_evt(2'd1, a + 8);
      expect_evt(2'd1, a + 11);
      cfg(2'd1, 1'b1, 1'b0, 16'd2);
      check("periodic_armed", {28'd0, armed}, 32'h2);
      repeat (11) step();
      cfg(2'd1, 1'b0, 1'b0, 16'd0);
      repeat (3) step();
      check("periodic_sb_empty", sb_q.size(), 32'd0);
      check("periodic_disarmed", {28'd0, armed}, 32'd0);

      // Oneshot ch2, period 0: one event, armed drops the cycle after the tick.
      reset_dut();
      a = cyc_cnt;
      expect_evt(2'd2, a + 3);
      cfg(2'd2, 1'b1, 1'b1, 16'd0);
      check("oneshot_armed", {28'd0, armed}, 32'h4);
      step();
      check("oneshot_armed_fall", {28'd0, armed}, 32'd0);
      repeat (6) step();
      check("oneshot_sb_empty", sb_q.size(), 32'd0);

      // Round-robin under stall: ch0 held, all overrun, then drained in order.
      reset_dut();
      expire_ready = 1'b0;
      cfg(2'd0, 1'b1, 1'b0, 16'd0);
      cfg(2'd1, 1'b1, 1'b0, 16'd0);
      cfg(2'd2, 1'b1, 1'b0, 16'd0);
      cfg(2'd3, 1'b1, 1'b0, 16'd0);
      for (int k = 0; k < 9; k++) begin
         check($sformatf("stall_valid%0d", k), {31'd0, expire_valid}, 32'd1);
         check($sformatf("stall_chan%0d", k), {30'd0, expire_chan}, 32'd0);
         step();
      end
      check("stall_overrun", {28'd0, overrun}, 32'hF);
      b = cyc_cnt;
      for (int k = 0; k < 4; k++) expect_evt(2'(k), b + k);
      expire_ready = 1'b1;
      repeat (4) step();
      expire_ready = 1'b0;
      check("rr_sb_empty", sb_q.size(), 32'd0);

      // Asynchronous reset while an event is presented.
      check("pre_reset_valid", {31'd0, expire_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      #1;
      rst_n = 1'b1;
      step();
      check("post_reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      check("post_reset_valid", {31'd0, expire_valid}, 32'd0);
      check("post_reset_overrun", {28'd0, overrun}, 32'd0);

      // Re-arm ch0 on its expiring tick; ch1 oneshot expires in that same cycle.
      reset_dut();
      a = cyc_cnt;
      expect_evt(2'd0, a + 4);
      expect_evt(2'd1, a + 6);
      expect_evt(2'd0, a + 12);
      cfg(2'd0, 1'b1, 1'b0, 16'd1);
      cfg(2'd1, 1'b1, 1'b1, 16'd2);
      repeat (2) step();
      cfg(2'd0, 1'b1, 1'b0, 16'd5);
      repeat (8) step();
      cfg(2'd0, 1'b0, 1'b0, 16'd0);
      repeat (4) step();
      check("collision_sb_empty", sb_q.size(), 32'd0);
      check("collision_armed", {28'd0, armed}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
